reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 33 +++
 rtl/reg_file_scan_ctrl.sv | 45 ++++
 rtl/reg_file.sv | 84 ++++++++
 tb/tb_reg_file.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared datapath geometry for the register file, ALU and control path.
// Also provides the read-with-forwarding rule used by every read port.
package reg_file_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

    // en is already qualified: wr_en, non-zero address and reset released.
    typedef struct packed {
        logic      en;
        reg_addr_t addr;
        reg_data_t data;
    } wr_req_t;

    function automatic reg_data_t read_fwd(input reg_addr_t addr,
                                           input wr_req_t   wr,
                                           input reg_data_t stored);
        if (addr == ZERO_REG) begin
            return '0;
        end
        if (wr.en && (wr.addr == addr)) begin
            return wr.data;
        end
        return stored;
    endfunction

endpackage

// File: rtl/reg_file_scan_ctrl.sv
// Debug-scan stepping: auto prescaler or manual edge-detected step request.
// Produces a single-cycle advance pulse for the debug address counter.
module scan_ctrl #(
    parameter int SCAN_DIV = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic scan_mode,
    input  logic scan_step,
    output logic advance
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TERM_CNT = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          step_prev_q;
    logic          auto_tick;
    logic          manual_tick;

    assign auto_tick   = scan_mode && (presc_q == TERM_CNT);
    assign manual_tick = !scan_mode && scan_step && !step_prev_q;
    assign advance     = auto_tick || manual_tick;

    // Holding the prescaler at 0 in manual mode makes every entry to auto mode start a full period.
    // NOTE: presc_d gets a default first so no path through this block can infer a latch.
    always_comb begin
        presc_d = '0;
        if (scan_mode && !auto_tick) begin
            presc_d = presc_q + PW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q     <= '0;
            step_prev_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            step_prev_q <= scan_step;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32x32 register file, two combinational read ports with write-before-read
// forwarding, plus a scanning debug read port.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int SCAN_DIV = 100000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  scan_mode,
    input  logic                  scan_step,
    output logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    reg_data_t regs_q [REG_COUNT];
    reg_addr_t dbg_addr_q, dbg_addr_d;
    wr_req_t   wr;
    logic      advance;

    scan_ctrl #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_ctrl (
        .clk       (clk),
        .reset     (reset),
        .scan_mode (scan_mode),
        .scan_step (scan_step),
        .advance   (advance)
    );

    // Gating with reset keeps forwarding from leaking wr_data while the file is held clear.
    always_comb begin
        wr.en   = wr_en && reset && (wr_addr != ZERO_REG);
        wr.addr = wr_addr;
        wr.data = wr_data;
    end

    always_comb begin
        rs_data  = read_fwd(rs_addr,    wr, regs_q[rs_addr]);
        rt_data  = read_fwd(rt_addr,    wr, regs_q[rt_addr]);
        dbg_data = read_fwd(dbg_addr_q, wr, regs_q[dbg_addr_q]);
    end

    always_comb begin
        dbg_addr_d = dbg_addr_q;
        if (advance) begin
            dbg_addr_d = dbg_addr_q + REG_ADDR_W'(1);
        end
    end

    assign dbg_addr = dbg_addr_q;

    // NOTE: the storage array is reset because the file must read all-zero while reset is held,
    // which rules out a plain RAM macro here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (wr.en && (wr.addr == REG_ADDR_W'(i))) begin
                    regs_q[i] <= wr.data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbg_addr_q <= '0;
        end else begin
            dbg_addr_q <= dbg_addr_d;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: vector table for read/write/forwarding,
// hand sequences for reset, manual/auto scan and write+step collision.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr, wr_addr;
    logic [31:0] rs_data, rt_data, wr_data, dbg_data;
    logic        wr_en, scan_mode, scan_step;
    logic [4:0]  dbg_addr;

    int n_cmp;
    int n_err;

    reg_file #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .scan_mode (scan_mode),
        .scan_step (scan_step),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_step();
        scan_step = 1'b1;
        tick();
        scan_step = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        vecs[0]  = '{1'b1, 5'd1,  32'h1111_1111, 5'd1,  5'd2,  32'h1111_1111, 32'h0};
        vecs[1]  = '{1'b1, 5'd2,  32'h0000_2222, 5'd1,  5'd2,  32'h1111_1111, 32'h0000_2222};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,         5'd2,  5'd1,  32'h0000_2222, 32'h1111_1111};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd1,  32'h0,         32'h1111_1111};
        vecs[5]  = '{1'b1, 5'd7,  32'h0000_0011, 5'd7,  5'd7,  32'h0000_0011, 32'h0000_0011};
        vecs[6]  = '{1'b1, 5'd7,  32'h0000_0022, 5'd7,  5'd7,  32'h0000_0022, 32'h0000_0022};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd7,  32'h0000_0022, 32'h0000_0022};
        vecs[8]  = '{1'b0, 5'd1,  32'h0000_0BAD, 5'd1,  5'd1,  32'h1111_1111, 32'h1111_1111};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,         5'd1,  5'd31, 32'h1111_1111, 32'h0};
        vecs[10] = '{1'b1, 5'd31, 32'hFFFF_0000, 5'd31, 5'd30, 32'hFFFF_0000, 32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd0,  32'hFFFF_0000, 32'h0};
        vecs[12] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd7,  32'hDEAD_BEEF, 32'h0000_0022};

        // Reset held from time 0 with a write attempt that must not forward or land.
        reset     = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 5'd5;
        wr_data   = 32'h1234_5678;
        rs_addr   = 5'd5;
        rt_addr   = 5'd5;
        scan_mode = 1'b0;
        scan_step = 1'b1;
        #2;
        check("reset_rs_nofwd", rs_data, 32'h0);
        check("reset_rt_nofwd", rt_data, 32'h0);
        tick();
        tick();
        check("reset_rs_after_edges", rs_data, 32'h0);
        check("reset_dbg_addr", {27'b0, dbg_addr}, 32'd0);
        check("reset_dbg_data", dbg_data, 32'h0);

        wr_en     = 1'b0;
        scan_step = 1'b0;
        reset     = 1'b1;
        #1;

        for (int i = 0; i < 13; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data;
            rs_addr = vecs[i].rs_addr;
            rt_addr = vecs[i].rt_addr;
            #1;
            check($sformatf("vec%0d_rs", i), rs_data, vecs[i].exp_rs);
            check($sformatf("vec%0d_rt", i), rt_data, vecs[i].exp_rt);
            tick();
        end
        wr_en = 1'b0;
        rs_addr = 5'd5;
        #1;
        check("r5_stored", rs_data, 32'hDEAD_BEEF);

        // Move dbg_addr off zero, then reset asynchronously between edges.
        pulse_step();
        check("manual_step_one", {27'b0, dbg_addr}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrun_reset_rs", rs_data, 32'h0);
        check("midrun_reset_dbg_addr", {27'b0, dbg_addr}, 32'd0);
        wr_en = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'h5555_5555;
        #1;
        check("midrun_reset_nofwd", rs_data, 32'h0);
        wr_en = 1'b0;
        tick();
        reset = 1'b1;

        // First edge after release accepts a write; then manual scan.
        wr_en = 1'b1;
        wr_addr = 5'd4;
        wr_data = 32'h0000_4444;
        tick();
        wr_en = 1'b0;
        rs_addr = 5'd4;
        #1;
        check("first_write_after_reset", rs_data, 32'h0000_4444);
        scan_step = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        scan_step = 1'b0;
        tick();
        check("held_step_once", {27'b0, dbg_addr}, 32'd1);
        for (int i = 0; i < 3; i++) pulse_step();
        check("manual_dbg_addr", {27'b0, dbg_addr}, 32'd4);
        check("manual_dbg_data", dbg_data, 32'h0000_4444);

        // Write+step collision at dbg_addr=3.
        #2;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) pulse_step();
        check("collide_pre_addr", {27'b0, dbg_addr}, 32'd3);
        check("collide_pre_data", dbg_data, 32'h0);
        wr_en = 1'b1;
        wr_addr = 5'd4;
        wr_data = 32'h0000_CAFE;
        scan_step = 1'b1;
        tick();
        wr_en = 1'b0;
        scan_step = 1'b0;
        #1;
        check("collide_dbg_addr", {27'b0, dbg_addr}, 32'd4);
        check("collide_dbg_data", dbg_data, 32'h0000_CAFE);
        wr_en = 1'b1;
        wr_data = 32'h0000_BEEF;
        #1;
        check("dbg_forward", dbg_data, 32'h0000_BEEF);
        tick();
        wr_en = 1'b0;
        #1;
        check("dbg_after_write", dbg_data, 32'h0000_BEEF);

        // Auto scan from reset with SCAN_DIV=4.
        #2;
        reset = 1'b0;
        scan_mode = 1'b1;
        #1;
        reset = 1'b1;
        for (int n = 1; n <= 130; n++) begin
            tick();
            if (n % 4 == 0 || n == 130) begin
                check($sformatf("auto_c%0d", n), {27'b0, dbg_addr}, 32'((n / 4) % 32));
            end
        end
        check("auto_wrap_final", {27'b0, dbg_addr}, 32'd0);

        // Leaving auto mode clears the prescaler; re-entry waits a full period.
        scan_mode = 1'b0;
        tick();
        scan_mode = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("restart_no_early_step", {27'b0, dbg_addr}, 32'd0);
        tick();
        check("restart_full_period", {27'b0, dbg_addr}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
